// File: rtl/enc_pulse_gen_if.sv
// Bundle of run control, configuration and generated outputs for one
// encoder pulse generator channel (A/Z pair).
//
// Handshake semantics: there is no valid/ready pair here. 'en' is a
// level-sensitive run request sampled on every rising clk edge. The config
// fields (high, low, z_num, burst) are sampled only on the edge that starts
// a run from IDLE. All slave outputs are registered and change only on
// rising clk edges or on asynchronous reset.
interface enc_pulse_gen_if #(
  parameter int P_W  = 32,
  parameter int P_ZW = 16
);
  // run control and configuration (master -> slave)
  logic            en;
  logic [P_W-1:0]  high;
  logic [P_W-1:0]  low;
  logic [P_ZW-1:0] z_num;
  logic [P_W-1:0]  burst;

  // generated signals and status (slave -> master)
  logic            a;
  logic            z;
  logic            busy;
  logic            done;
  logic            cfg_err;
  logic [63:0]     pulse_cnt;
  // FSM state for observation: 0 IDLE, 1 HIGH, 2 LOW, 3 DONE
  logic [1:0]      state;

  modport master (
    output en, high, low, z_num, burst,
    input  a, z, busy, done, cfg_err, pulse_cnt, state
  );

  modport slave (
    input  en, high, low, z_num, burst,
    output a, z, busy, done, cfg_err, pulse_cnt, state
  );
endinterface

// File: rtl/enc_pulse_gen.sv
// Encoder A/Z pulse generator. Emits an A pulse train with programmable
// high/low widths (in clk cycles), a one-cycle Z index pulse every z_num
// A pulses, and optionally stops after a fixed number of pulses (burst).
// Used as an on-chip loopback source for the encoder counter channel.
module enc_pulse_gen #(
  parameter int P_W  = 32,
  parameter int P_ZW = 16
) (
  input  logic           clk,
  input  logic           rst,
  enc_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_q;

  // configuration captured at start; inputs are ignored while running
  logic [P_W-1:0]  high_sh;
  logic [P_W-1:0]  low_sh;
  logic [P_ZW-1:0] z_num_sh;
  logic [P_W-1:0]  burst_sh;

  // remaining cycles in the current HIGH or LOW phase, counts down to 0
  logic [P_W-1:0]  per_cnt;
  // A rises since the last Z (always below z_num)
  logic [P_ZW-1:0] z_cnt;
  // Z is due on the cycle after the rise that completed a Z group
  logic            z_pend;

  logic            a_q;
  logic            z_q;
  logic            busy_q;
  logic            done_q;
  logic            cfg_err_q;
  logic [63:0]     pulse_cnt_q;

  logic            cfg_ok;
  logic [P_ZW-1:0] z_lim;
  logic [P_ZW-1:0] z_inc;
  logic            z_hit;
  logic            burst_end;

  // Start qualification and the Z-counter step applied on every A rise.
  // A rise from IDLE uses the live z_num and a freshly cleared counter;
  // later rises use the captured z_num and the running counter.
  always_comb begin
    cfg_ok    = (bus.high != '0) && (bus.low != '0) && (bus.z_num != '0);
    z_lim     = z_num_sh;
    z_inc     = z_cnt + P_ZW'(1);
    if (state_q == ST_IDLE) begin
      z_lim = bus.z_num;
      z_inc = P_ZW'(1);
    end
    z_hit     = (z_inc == z_lim);
    burst_end = (burst_sh != '0) && (pulse_cnt_q == 64'(burst_sh));
  end

  // Pulse FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      high_sh     <= '0;
      low_sh      <= '0;
      z_num_sh    <= '0;
      burst_sh    <= '0;
      per_cnt     <= '0;
      z_cnt       <= '0;
      z_pend      <= 1'b0;
      a_q         <= 1'b0;
      z_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      // Z is a one-cycle echo of the pending flag set at an A rise
      z_q    <= z_pend;
      z_pend <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.en && cfg_ok) begin
            high_sh     <= bus.high;
            low_sh      <= bus.low;
            z_num_sh    <= bus.z_num;
            burst_sh    <= bus.burst;
            per_cnt     <= bus.high - P_W'(1);
            a_q         <= 1'b1;
            busy_q      <= 1'b1;
            cfg_err_q   <= 1'b0;
            pulse_cnt_q <= 64'd1;
            z_cnt       <= z_hit ? '0 : z_inc;
            z_pend      <= z_hit;
            state_q     <= ST_HIGH;
          end else begin
            // set only while a start is requested with a zero field
            cfg_err_q <= bus.en;
          end
        end

        ST_HIGH: begin
          if (per_cnt == '0) begin
            a_q     <= 1'b0;
            per_cnt <= low_sh - P_W'(1);
            state_q <= ST_LOW;
          end else begin
            per_cnt <= per_cnt - P_W'(1);
          end
        end

        ST_LOW: begin
          if (per_cnt != '0) begin
            per_cnt <= per_cnt - P_W'(1);
          end else if (burst_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (!bus.en) begin
            // stop only at a period boundary so no pulse is truncated
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            a_q         <= 1'b1;
            per_cnt     <= high_sh - P_W'(1);
            pulse_cnt_q <= pulse_cnt_q + 64'd1;
            z_cnt       <= z_hit ? '0 : z_inc;
            z_pend      <= z_hit;
            state_q     <= ST_HIGH;
          end
        end

        ST_DONE: begin
          if (!bus.en) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.z         = z_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.pulse_cnt = pulse_cnt_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_enc_pulse_gen.sv
// Directed bench for enc_pulse_gen. Inputs change and outputs are sampled
// on the falling clk edge; "after edge k" means the falling edge following
// the k-th rising edge counted from the start edge (edge 0).
module tb_enc_pulse_gen;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_DONE = 2'd3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  enc_pulse_gen_if #(.P_W(32), .P_ZW(16)) bus ();

  enc_pulse_gen #(.P_W(32), .P_ZW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock: 10 ns period, rising edges at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drop the run request and wait (bounded) for the channel to go idle
  task automatic stop_and_wait(input string tag);
    int n;
    bus.en = 1'b0;
    n = 0;
    while ((bus.busy !== 1'b0 || bus.state !== S_IDLE) && n < 40) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(bus.state), 64'(S_IDLE));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.high  = 32'd2;
    bus.low   = 32'd3;
    bus.z_num = 16'd3;
    bus.burst = 32'd0;

    // ---------------- reset values
    tick(3);
    chk("rst_a",     64'(bus.a),       64'd0);
    chk("rst_z",     64'(bus.z),       64'd0);
    chk("rst_busy",  64'(bus.busy),    64'd0);
    chk("rst_done",  64'(bus.done),    64'd0);
    chk("rst_err",   64'(bus.cfg_err), 64'd0);
    chk("rst_cnt",   bus.pulse_cnt,    64'd0);
    chk("rst_state", 64'(bus.state),   64'(S_IDLE));
    rst = 1'b0;
    tick(2);

    // ---------------- continuous run H=2 L=3 Z_NUM=3
    // A rises every 5 edges from edge 0; Z follows rises 3, 6, 9
    // (edges 10, 25, 40) by one cycle.
    bus.en = 1'b1;
    for (int k = 0; k <= 41; k++) begin
      tick(1);
      chk($sformatf("cont_a_e%0d", k), 64'(bus.a), 64'((k % 5) < 2));
      chk($sformatf("cont_z_e%0d", k), 64'(bus.z), 64'(k == 11 || k == 26 || k == 41));
      chk($sformatf("cont_busy_e%0d", k), 64'(bus.busy), 64'd1);
      if (k == 15) chk("cont_cnt_e15", bus.pulse_cnt, 64'd4);
    end
    // rises at 0,5,...,40; the period in flight finishes, no new rise
    stop_and_wait("cont_stop_idle");
    chk("cont_stop_cnt",  bus.pulse_cnt, 64'd9);
    chk("cont_stop_a",    64'(bus.a),    64'd0);
    chk("cont_stop_done", 64'(bus.done), 64'd0);

    // ---------------- burst of 5, H=1 L=1
    // rises at 0,2,4,6,8; third rise (edge 4) gives Z after edge 5;
    // edge 10 leaves the final LOW into DONE.
    bus.high  = 32'd1;
    bus.low   = 32'd1;
    bus.burst = 32'd5;
    bus.en    = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      tick(1);
      chk($sformatf("burst_a_e%0d", k), 64'(bus.a), 64'((k % 2) == 0));
      chk($sformatf("burst_z_e%0d", k), 64'(bus.z), 64'(k == 5));
      chk($sformatf("burst_busy_e%0d", k), 64'(bus.busy), 64'd1);
    end
    tick(1);
    chk("burst_done_e10",  64'(bus.done),  64'd1);
    chk("burst_busy_e10",  64'(bus.busy),  64'd0);
    chk("burst_a_e10",     64'(bus.a),     64'd0);
    chk("burst_cnt_e10",   bus.pulse_cnt,  64'd5);
    chk("burst_state_e10", 64'(bus.state), 64'(S_DONE));
    for (int k = 11; k <= 14; k++) begin
      tick(1);
      chk($sformatf("burst_hold_a_e%0d", k), 64'(bus.a), 64'd0);
      chk($sformatf("burst_hold_done_e%0d", k), 64'(bus.done), 64'd1);
    end
    bus.en = 1'b0;
    tick(1);
    chk("burst_release_done",  64'(bus.done),  64'd0);
    chk("burst_release_state", 64'(bus.state), 64'(S_IDLE));
    chk("burst_release_cnt",   bus.pulse_cnt,  64'd5);
    bus.en = 1'b1;
    tick(1);
    chk("burst_restart_a",   64'(bus.a),    64'd1);
    chk("burst_restart_cnt", bus.pulse_cnt, 64'd1);
    stop_and_wait("burst_restart_idle");

    // ---------------- en dropped during HIGH of pulse 2, H=4 L=4
    // pulse 2 occupies edges 8..15; edge 16 leaves the final LOW.
    bus.high  = 32'd4;
    bus.low   = 32'd4;
    bus.burst = 32'd0;
    bus.en    = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick(1);
      if (k == 9) bus.en = 1'b0;
      chk($sformatf("drop_a_e%0d", k), 64'(bus.a), 64'((k < 16) && ((k % 8) < 4)));
      chk($sformatf("drop_busy_e%0d", k), 64'(bus.busy), 64'(k < 16));
    end
    chk("drop_cnt", bus.pulse_cnt, 64'd2);
    for (int k = 17; k <= 24; k++) begin
      tick(1);
      chk($sformatf("drop_quiet_a_e%0d", k), 64'(bus.a), 64'd0);
    end

    // ---------------- zero config refused, then accepted
    bus.high = 32'd2;
    bus.low  = 32'd0;
    bus.en   = 1'b1;
    tick(3);
    chk("cfg_err_set",   64'(bus.cfg_err), 64'd1);
    chk("cfg_err_a",     64'(bus.a),       64'd0);
    chk("cfg_err_busy",  64'(bus.busy),    64'd0);
    chk("cfg_err_state", 64'(bus.state),   64'(S_IDLE));
    bus.low = 32'd2;
    tick(1);
    chk("cfg_fix_a",     64'(bus.a),       64'd1);
    chk("cfg_fix_err",   64'(bus.cfg_err), 64'd0);
    chk("cfg_fix_cnt",   bus.pulse_cnt,    64'd1);
    chk("cfg_fix_state", 64'(bus.state),   64'(S_HIGH));
    stop_and_wait("cfg_fix_idle");

    // ---------------- async reset mid-HIGH with Z counter at 2
    bus.high  = 32'd2;
    bus.low   = 32'd3;
    bus.z_num = 16'd3;
    bus.en    = 1'b1;
    tick(6);                 // after edge 5: second pulse high
    chk("rstmid_pre_a",   64'(bus.a),    64'd1);
    chk("rstmid_pre_cnt", bus.pulse_cnt, 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_a",    64'(bus.a),       64'd0);
    chk("rstmid_z",    64'(bus.z),       64'd0);
    chk("rstmid_busy", 64'(bus.busy),    64'd0);
    chk("rstmid_done", 64'(bus.done),    64'd0);
    chk("rstmid_err",  64'(bus.cfg_err), 64'd0);
    chk("rstmid_cnt",  bus.pulse_cnt,    64'd0);
    tick(2);
    rst = 1'b0;
    // Z counter restarts: Z only after the third new rise (edge 10)
    for (int k = 0; k <= 12; k++) begin
      tick(1);
      chk($sformatf("rstmid_re_a_e%0d", k), 64'(bus.a), 64'((k % 5) < 2));
      chk($sformatf("rstmid_re_z_e%0d", k), 64'(bus.z), 64'(k == 11));
    end
    chk("rstmid_re_cnt", bus.pulse_cnt, 64'd3);
    stop_and_wait("rstmid_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
